// File: rtl/arb_mux_rtl.sv
// N-to-1 round-robin arbitrated mux with val/rdy channels and a one-entry output buffer.
// Define ARB_MUX_SEL_OUT_EN to expose the registered source index on out_sel.
module arb_mux_rtl #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 32,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN-1:0]       in_val,
  output logic [NUM_IN-1:0]       in_rdy,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [WIDTH-1:0]        out_data
`ifdef ARB_MUX_SEL_OUT_EN
  ,
  output logic [SEL_W-1:0]        out_sel
`endif
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] gnt;
  logic             gnt_vld;
  logic             load_en;
  logic             take;
  logic [WIDTH-1:0] gnt_data;

  assign load_en = (out_val == EMPTY) || out_rdy;

  // Scan from rr_ptr upward, wrapping at NUM_IN rather than 2^SEL_W.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!gnt_vld && in_val[idx]) begin
        gnt_vld = 1'b1;
        gnt     = SEL_W'(idx);
      end
    end
  end

  assign gnt_data = in_data[int'(gnt)*WIDTH +: WIDTH];
  assign take     = gnt_vld && load_en && !rst;

  always_comb begin
    in_rdy = '0;
    if (take) in_rdy[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_val  <= EMPTY;
      out_data <= '0;
      rr_ptr   <= '0;
    end else if (take) begin
      out_val  <= FULL;
      out_data <= gnt_data;
      rr_ptr   <= (gnt == SEL_W'(NUM_IN - 1)) ? '0 : gnt + SEL_W'(1);
    end else if (out_val == FULL && out_rdy) begin
      out_val  <= EMPTY;
    end
  end

`ifdef ARB_MUX_SEL_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sel <= '0;
    end else if (take) begin
      out_sel <= gnt;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux_rtl.sv
// Bench for arb_mux_rtl: directed vector table, reset corner case, random vs reference model.
// Build with ARB_MUX_SEL_OUT_EN defined to also check out_sel.
module tb_arb_mux_rtl;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_val;
  logic [N-1:0]   in_rdy;
  logic [N*W-1:0] in_data;
  logic           out_val;
  logic           out_rdy;
  logic [W-1:0]   out_data;
`ifdef ARB_MUX_SEL_OUT_EN
  logic [1:0]     out_sel;
`endif

  arb_mux_rtl #(.NUM_IN(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_val(in_val),
    .in_rdy(in_rdy),
    .in_data(in_data),
    .out_val(out_val),
    .out_rdy(out_rdy),
    .out_data(out_data)
`ifdef ARB_MUX_SEL_OUT_EN
    ,
    .out_sel(out_sel)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]   iv;
    logic [N*W-1:0] d;
    logic           ordy;
    logic [N-1:0]   rdy;
    logic           ov;
    logic           cod;
    logic [W-1:0]   od;
    logic [1:0]     sel;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [N-1:0] iv, input logic [N*W-1:0] d,
                              input logic ordy, input logic [N-1:0] rdy,
                              input logic ov, input logic cod,
                              input logic [W-1:0] od, input logic [1:0] sel);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.rdy = rdy;
    v.ov = ov; v.cod = cod; v.od = od; v.sel = sel;
    return v;
  endfunction

  localparam logic [N*W-1:0] D_RR = {32'h13, 32'h12, 32'h11, 32'h10};
  localparam logic [N*W-1:0] D_A5 = {32'h0, 32'hA5, 32'h0, 32'h0};
  localparam logic [N*W-1:0] D_DB = {32'h23, 32'h22, 32'hDEAD_BEEF, 32'h20};

  // reference model state
  logic         m_val;
  logic [W-1:0] m_data;
  int           m_ptr;
  int           m_sel;

  initial begin
    rst = 1'b1;
    in_val = 4'b1111;
    in_data = D_RR;
    out_rdy = 1'b1;

    // idle/reset state with requests pending: nothing may be granted
    @(posedge clk); #1;
    chk("rst out_val", out_val, 0);
    chk("rst in_rdy", in_rdy, 0);
    chk("rst out_data", out_data, 0);
`ifdef ARB_MUX_SEL_OUT_EN
    chk("rst out_sel", out_sel, 0);
`endif
    @(posedge clk); #1;
    in_val = '0;
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'b0000, D_RR, 1, 4'b0000, 0, 1, 32'h0, 0));
    tbl.push_back(mk(4'b0100, D_A5, 1, 4'b0100, 0, 1, 32'h0, 0));
    tbl.push_back(mk(4'b0100, D_A5, 1, 4'b0100, 1, 1, 32'hA5, 2));
    tbl.push_back(mk(4'b0100, D_A5, 1, 4'b0100, 1, 1, 32'hA5, 2));
    tbl.push_back(mk(4'b1111, D_RR, 1, 4'b1000, 1, 1, 32'hA5, 2));
    tbl.push_back(mk(4'b1111, D_RR, 1, 4'b0001, 1, 1, 32'h13, 3));
    tbl.push_back(mk(4'b1111, D_RR, 1, 4'b0010, 1, 1, 32'h10, 0));
    tbl.push_back(mk(4'b1111, D_RR, 1, 4'b0100, 1, 1, 32'h11, 1));
    tbl.push_back(mk(4'b1111, D_RR, 1, 4'b1000, 1, 1, 32'h12, 2));
    tbl.push_back(mk(4'b1111, D_RR, 1, 4'b0001, 1, 1, 32'h13, 3));
    tbl.push_back(mk(4'b0010, D_DB, 1, 4'b0010, 1, 1, 32'h10, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(4'b1111, D_DB, 0, 4'b0000, 1, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk(4'b1111, D_DB, 1, 4'b0100, 1, 1, 32'hDEAD_BEEF, 1));
    tbl.push_back(mk(4'b0000, D_DB, 1, 4'b0000, 1, 1, 32'h22, 2));
    tbl.push_back(mk(4'b0000, D_DB, 1, 4'b0000, 0, 0, 32'h0, 0));
    tbl.push_back(mk(4'b0010, D_RR, 1, 4'b0010, 0, 0, 32'h0, 0));
    tbl.push_back(mk(4'b0000, D_RR, 1, 4'b0000, 1, 1, 32'h11, 1));
    tbl.push_back(mk(4'b0000, D_RR, 1, 4'b0000, 0, 0, 32'h0, 0));
    tbl.push_back(mk(4'b0101, D_RR, 1, 4'b0100, 0, 0, 32'h0, 0));
    tbl.push_back(mk(4'b0101, D_RR, 1, 4'b0001, 1, 1, 32'h12, 2));
    tbl.push_back(mk(4'b0000, D_RR, 1, 4'b0000, 1, 1, 32'h10, 0));

    foreach (tbl[i]) begin
      in_val = tbl[i].iv;
      in_data = tbl[i].d;
      out_rdy = tbl[i].ordy;
      #2;
      chk($sformatf("tbl%0d in_rdy", i), in_rdy, tbl[i].rdy);
      chk($sformatf("tbl%0d out_val", i), out_val, tbl[i].ov);
      if (tbl[i].cod)
        chk($sformatf("tbl%0d out_data", i), out_data, tbl[i].od);
`ifdef ARB_MUX_SEL_OUT_EN
      if (tbl[i].ov)
        chk($sformatf("tbl%0d out_sel", i), out_sel, tbl[i].sel);
`endif
      @(posedge clk); #1;
    end

    // async reset between edges while full; priority returns to channel 0
    in_val = 4'b1111;
    in_data = D_RR;
    out_rdy = 1'b0;
    @(posedge clk); #1;
    chk("pre-rst out_val", out_val, 1);
    #2 rst = 1'b1;
    #1;
    chk("async rst out_val", out_val, 0);
    chk("async rst in_rdy", in_rdy, 0);
    chk("async rst out_data", out_data, 0);
    #1 rst = 1'b0;
    out_rdy = 1'b1;
    #1;
    chk("post-rst in_rdy", in_rdy, 4'b0001);
    @(posedge clk); #1;
    chk("post-rst out_val", out_val, 1);
    chk("post-rst out_data", out_data, 32'h10);
`ifdef ARB_MUX_SEL_OUT_EN
    chk("post-rst out_sel", out_sel, 0);
`endif

    // random traffic against a distance-based priority model
    rst = 1'b1;
    #1 rst = 1'b0;
    m_val = 1'b0;
    m_data = '0;
    m_ptr = 0;
    m_sel = 0;
    for (int c = 0; c < 400; c++) begin
      int best;
      int bd;
      logic [N-1:0] exp_rdy;
      in_val = 4'($urandom_range(0, 15));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      out_rdy = ($urandom_range(0, 3) != 0);
      #1;
      best = -1;
      bd = N;
      for (int i = 0; i < N; i++) begin
        if (in_val[i] && ((i - m_ptr + N) % N) < bd) begin
          bd = (i - m_ptr + N) % N;
          best = i;
        end
      end
      exp_rdy = '0;
      if (best >= 0 && (!m_val || out_rdy)) exp_rdy[best] = 1'b1;
      chk($sformatf("rnd%0d in_rdy", c), in_rdy, exp_rdy);
      chk($sformatf("rnd%0d out_val", c), out_val, m_val);
      if (m_val) begin
        chk($sformatf("rnd%0d out_data", c), out_data, m_data);
`ifdef ARB_MUX_SEL_OUT_EN
        chk($sformatf("rnd%0d out_sel", c), out_sel, m_sel);
`endif
      end
      if (exp_rdy != 0) begin
        m_val = 1'b1;
        m_data = in_data[best*W +: W];
        m_sel = best;
        m_ptr = (best + 1) % N;
      end else if (m_val && out_rdy) begin
        m_val = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
